// File: rtl/imm_encoder.sv
// RISC-V immediate encoder with a 2-entry output FIFO.
// Takes an instruction template plus an immediate and a format select, places
// the immediate bits into the format's fields, flags immediates that do not fit,
// and queues the result behind a valid/ready handshake. Also counts accepted
// requests and errored requests, both saturating.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Base,
    input  logic [31:0] Imm,
    input  logic [2:0]  ImmSrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Inst,
    output logic        out_err,
    output logic [15:0] EncCount,
    output logic [15:0] ErrCount
);

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } entry_t;

    entry_t      enc;
    entry_t      mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    // Merge the immediate into the template and flag out-of-range immediates.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // a format that leaves a field untouched cannot infer a latch.
        enc.inst = Base;
        enc.err  = 1'b0;
        case (ImmSrc)
            FMT_I: begin
                enc.inst[31:20] = Imm[11:0];
                enc.err         = (Imm[31:11] != {21{Imm[31]}});
            end
            FMT_S: begin
                enc.inst[31:25] = Imm[11:5];
                enc.inst[11:7]  = Imm[4:0];
                enc.err         = (Imm[31:11] != {21{Imm[31]}});
            end
            FMT_B: begin
                enc.inst[31]    = Imm[12];
                enc.inst[7]     = Imm[11];
                enc.inst[30:25] = Imm[10:5];
                enc.inst[11:8]  = Imm[4:1];
                enc.err         = (Imm[31:12] != {20{Imm[31]}}) || Imm[0];
            end
            FMT_J: begin
                enc.inst[31]    = Imm[20];
                enc.inst[19:12] = Imm[19:12];
                enc.inst[20]    = Imm[11];
                enc.inst[30:21] = Imm[10:1];
                enc.err         = (Imm[31:20] != {12{Imm[31]}}) || Imm[0];
            end
            FMT_U: begin
                enc.inst[31:12] = Imm[31:12];
                enc.err         = (Imm[11:0] != 12'd0);
            end
            default: begin
                // Reserved selects pass the template through untouched.
                enc.err = 1'b1;
            end
        endcase
    end

    // Readiness depends on registered occupancy and reset only, never on out_ready.
    assign in_ready  = rst_n && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign Inst      = mem[rd_ptr].inst;
    assign out_err   = mem[rd_ptr].err;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage is only two entries and the head is visible on
            // Inst, so it is cleared on reset to make Inst read zero afterwards.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Saturating request and error counters, stepped on each input transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            EncCount <= 16'd0;
            ErrCount <= 16'd0;
        end else if (push) begin
            if (EncCount != 16'hFFFF) begin
                EncCount <= EncCount + 16'd1;
            end
            if (enc.err && (ErrCount != 16'hFFFF)) begin
                ErrCount <= ErrCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed encodes, range errors,
// backpressure through the 2-entry FIFO and reset in mid-operation.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Base;
    logic [31:0] Imm;
    logic [2:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Inst;
    logic        out_err;
    logic [15:0] EncCount;
    logic [15:0] ErrCount;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Base      (Base),
        .Imm       (Imm),
        .ImmSrc    (ImmSrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Inst      (Inst),
        .out_err   (out_err),
        .EncCount  (EncCount),
        .ErrCount  (ErrCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   passed = 0;
    int   total  = 0;
    int   n_acc  = 0;
    int   n_pop  = 0;
    int   exp_enc = 0;
    int   exp_errc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference encoder: mask out the format's immediate field, OR in the
    // rearranged immediate, and range-check the signed value.
    function automatic exp_t model(input logic [31:0] base, input logic [31:0] imm,
                                   input logic [2:0] src);
        exp_t        r;
        logic [31:0] mask;
        logic [31:0] field;
        int          s;
        s     = $signed(imm);
        mask  = 32'h0;
        field = 32'h0;
        r.err = 1'b1;
        case (src)
            3'd0: begin
                mask  = 32'hFFF00000;
                field = {imm[11:0], 20'b0};
                r.err = (s < -2048) || (s > 2047);
            end
            3'd1: begin
                mask  = 32'hFE000F80;
                field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                r.err = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                mask  = 32'hFE000F80;
                field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                r.err = (s < -4096) || (s > 4095) || imm[0];
            end
            3'd3: begin
                mask  = 32'hFFFFF000;
                field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
                r.err = (s < -1048576) || (s > 1048575) || imm[0];
            end
            3'd4: begin
                mask  = 32'hFFFFF000;
                field = {imm[31:12], 12'b0};
                r.err = (imm[11:0] != 12'd0);
            end
            default: r.err = 1'b1;
        endcase
        r.inst = (base & ~mask) | field;
        return r;
    endfunction

    task automatic drive_model(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s);
        Base = b; Imm = i; ImmSrc = s; in_valid = 1'b1;
        pend = model(b, i, s);
    endtask

    task automatic drive_exp(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s,
                             input logic [31:0] e_inst, input logic e_err);
        Base = b; Imm = i; ImmSrc = s; in_valid = 1'b1;
        pend.inst = e_inst;
        pend.err  = e_err;
    endtask

    // One clock: compare the head on a pop, then record an accept after the edge.
    task automatic step();
        logic acc;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                check("out_inst", Inst, q[0].inst);
                check("out_err", out_err, q[0].err);
                void'(q.pop_front());
            end
            n_pop++;
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            q.push_back(pend);
            in_valid = 1'b0;
            n_acc++;
            exp_enc++;
            if (pend.err) exp_errc++;
        end
    endtask

    task automatic accept();
        int start;
        start = n_acc;
        for (int k = 0; k < 20 && n_acc == start; k++) step();
        if (n_acc == start) check("accept_timeout", in_ready, 1'b1);
    endtask

    task automatic wait_out(input int n);
        int start;
        out_ready = 1'b1;
        start = n_pop;
        for (int k = 0; k < 30 && (n_pop - start) < n; k++) step();
        check("drain_count", n_pop - start, n);
        out_ready = 1'b0;
    endtask

    task automatic check_counts();
        check("EncCount", EncCount, exp_enc[15:0]);
        check("ErrCount", ErrCount, exp_errc[15:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Base = '0; Imm = '0; ImmSrc = '0;
        pend.inst = '0; pend.err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_inst", Inst, 32'h0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check_counts();

        // Requests presented during reset are ignored.
        drive_model(32'h00000013, 32'h5, 3'd0);
        step();
        check("rst_ignore_valid", out_valid, 1'b0);
        check("rst_ignore_cnt", EncCount, 16'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // I-type with one-cycle latency.
        drive_exp(32'h00000013, 32'hFFFFFFFF, 3'b000, 32'hFFF00013, 1'b0);
        accept();
        check("i_latency_valid", out_valid, 1'b1);
        check("i_inst", Inst, 32'hFFF00013);
        check("i_enc_count", EncCount, 16'd1);
        wait_out(1);

        // B-type, J-type, U range error, reserved select.
        drive_exp(32'h00000063, 32'h00000010, 3'b010, 32'h00000863, 1'b0);
        accept(); wait_out(1);
        drive_exp(32'h0000006F, 32'hFFFFFFFC, 3'b011, 32'hFFDFF06F, 1'b0);
        accept(); wait_out(1);
        drive_exp(32'h00000037, 32'h12345678, 3'b100, 32'h12345037, 1'b1);
        accept(); wait_out(1);
        check("u_err_count", ErrCount, 16'd1);
        drive_exp(32'h12345678, 32'h00000004, 3'b111, 32'h12345678, 1'b1);
        accept(); wait_out(1);
        check_counts();

        // Boundary immediates and remaining formats.
        drive_model(32'h00002023, 32'hFFFFFFF8, 3'd1); accept(); wait_out(1);
        drive_model(32'h00000013, 32'hFFFFF800, 3'd0); accept(); wait_out(1);
        drive_model(32'h00000013, 32'h00000800, 3'd0); accept(); wait_out(1);
        drive_model(32'h00000063, 32'h00000003, 3'd2); accept(); wait_out(1);
        drive_model(32'h00000063, 32'hFFFFF000, 3'd2); accept(); wait_out(1);
        drive_model(32'h0000006F, 32'h00100000, 3'd3); accept(); wait_out(1);
        drive_model(32'hABCDE037, 32'h00000000, 3'd4); accept(); wait_out(1);
        drive_model(32'h0000F00F, 32'h00000010, 3'd5); accept(); wait_out(1);
        check_counts();

        // Backpressure: three back-to-back requests into a stalled 2-entry FIFO.
        drive_model(32'h00000013, 32'h00000123, 3'd0); accept();
        check("bp_ready_1", in_ready, 1'b1);
        drive_model(32'h00002023, 32'hFFFFF9A5, 3'd1); accept();
        check("bp_ready_full", in_ready, 1'b0);
        drive_model(32'h0000006F, 32'h000ABCDE, 3'd3);
        step(); step();
        check("bp_held", in_valid, 1'b1);
        check("bp_still_full", in_ready, 1'b0);
        check("bp_head_stable", Inst, q[0].inst);
        check("bp_enc_count", EncCount, exp_enc[15:0]);
        wait_out(3);
        check("bp_empty", out_valid, 1'b0);
        check_counts();

        // Reset while two entries are queued.
        drive_model(32'h00000013, 32'h00000001, 3'd0); accept();
        drive_model(32'h00000037, 32'h00000FFF, 3'd4); accept();
        check("mid_full", in_ready, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        q.delete();
        exp_enc = 0;
        exp_errc = 0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_inst", Inst, 32'h0);
        check("mid_rst_ready", in_ready, 1'b1);
        check_counts();

        // Normal operation resumes after the reset.
        drive_exp(32'h00000013, 32'hFFFFFFFF, 3'b000, 32'hFFF00013, 1'b0);
        accept(); wait_out(1);
        check_counts();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst_n`: input, 1 bit, synchronous reset, active-low.
REQ-003 The block SHALL have the port `in_valid`: input, 1 bit, request present.
REQ-004 The block SHALL have the port `in_ready`: output, 1 bit, block can accept a request.
REQ-005 The block SHALL have the port `Base`: input, 32 bits, instruction template (opcode, rd, funct3, rs1, rs2, funct7 already in place).
REQ-006 The block SHALL have the port `Imm`: input, 32 bits, immediate value to encode.
REQ-007 The block SHALL have the port `ImmSrc`: input, 3 bits, format select: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-008 The block SHALL have the port `out_valid`: output, 1 bit, encoded instruction present.
REQ-009 The block SHALL have the port `out_ready`: input, 1 bit, consumer accepts the output.
REQ-010 The block SHALL have the port `Inst`: output, 32 bits, encoded instruction.
REQ-011 The block SHALL have the port `out_err`: output, 1 bit, immediate not representable or ImmSrc illegal; qualified by out_valid.
REQ-012 The block SHALL have the port `EncCount`: output, 16 bits, accepted-request count, saturating.
REQ-013 The block SHALL have the port `ErrCount`: output, 16 bits, accepted-request-with-error count, saturating.

Function
REQ-014 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-015 Encoding SHALL start from Base; only the immediate bit positions of the selected format are overwritten.
- I: Inst[31:20]=Imm[11:0].
- S: Inst[31:25]=Imm[11:5], Inst[11:7]=Imm[4:0].
- B: Inst[31]=Imm[12], Inst[7]=Imm[11], Inst[30:25]=Imm[10:5], Inst[11:8]=Imm[4:1].
- J: Inst[31]=Imm[20], Inst[19:12]=Imm[19:12], Inst[20]=Imm[11], Inst[30:21]=Imm[10:1].
- U: Inst[31:12]=Imm[31:12].
REQ-016 The error flag SHALL be set per format as follows.
- I/S: Imm[31:11] not all equal.
- B: Imm[31:12] not all equal, or Imm[0]=1.
- J: Imm[31:20] not all equal, or Imm[0]=1.
- U: Imm[11:0] nonzero.
- ImmSrc 101/110/111: Inst=Base unchanged, error=1.
REQ-017 An errored request SHALL still be encoded with the truncated fields and delivered, with out_err=1; it is never dropped.
REQ-018 Encoded results SHALL enter a 2-entry in-order output FIFO; the head drives Inst, out_err and out_valid (out_valid = FIFO non-empty).
REQ-019 Latency SHALL be one cycle: a request accepted at edge N makes out_valid=1 after edge N when the FIFO was empty.
REQ-020 in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries and rst_n=1; it is derived from registered occupancy only, with no combinational path from out_ready.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order; at occupancy 2 no push occurs (in_ready=0), so a pop alone frees one slot.
REQ-022 A pop on an empty FIFO SHALL NOT occur, and out_ready while out_valid=0 SHALL be ignored.
REQ-023 Inst and out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 EncCount SHALL increment by 1 per input transfer and hold at 0xFFFF.
REQ-025 ErrCount SHALL increment by 1 per input transfer whose error flag is 1 and hold at 0xFFFF.
REQ-026 Base, Imm and ImmSrc SHALL be don't-care when no input transfer occurs.

Reset
REQ-027 An edge with rst_n=0 SHALL empty the FIFO and set out_valid=0, Inst=0, out_err=0, EncCount=0 and ErrCount=0.
REQ-028 in_ready SHALL be 0 while rst_n=0, and inputs SHALL be ignored.
REQ-029 A reset asserted mid-operation SHALL discard all queued entries with no partial output.
REQ-030 in_ready SHALL be 1 on the first cycle after rst_n returns to 1.

Verification
REQ-031 The bench SHALL cover an I-type encode: Base=0x00000013, Imm=0xFFFFFFFF, ImmSrc=000 -> next cycle Inst=0xFFF00013, out_err=0, EncCount=1.
REQ-032 The bench SHALL cover a B-type encode: Base=0x00000063, Imm=0x00000010, ImmSrc=010 -> Inst=0x00000863, out_err=0.
REQ-033 The bench SHALL cover a J-type encode: Base=0x0000006F, Imm=0xFFFFFFFC, ImmSrc=011 -> Inst=0xFFDFF06F, out_err=0.
REQ-034 The bench SHALL cover a U-type range error: Base=0x00000037, Imm=0x12345678, ImmSrc=100 -> Inst=0x12345037, out_err=1, ErrCount=1; separately, ImmSrc=111 -> Inst=Base, out_err=1.
REQ-035 The bench SHALL cover backpressure: out_ready=0 and three back-to-back requests -> in_ready=0 after the second accept and the third is held; then out_ready=1 -> three outputs in order, with no loss or duplication.
REQ-036 The bench SHALL cover reset mid-operation: two entries queued, rst_n=0 for one edge -> out_valid=0, EncCount=0, ErrCount=0, in_ready=1 on the following cycle.
